// File: rtl/bus_pkg.sv
// Shared types for the bus RAM responder: access-size encoding and FSM states.
// The optional MISALIGN_ERR_EN build macro is consumed by bus_lane_align.
package bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } bus_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } bus_state_e;

endpackage

// File: rtl/bus_lane_align.sv
// Little-endian lane steering: byte enables, write-data replication, read extract.
// Define MISALIGN_ERR_EN to flag misaligned half/word accesses; otherwise low bits are ignored.
module bus_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misalign
);

`ifdef MISALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Write data is replicated across lanes so the byte enables alone pick the target lane.
  always_comb begin
    be       = 4'b0000;
    wdata_sh = '0;
    rdata    = '0;
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {4{wdata[7:0]}};
        rdata    = {24'h0, mem_word[8*addr_lo +: 8]};
      end
      SIZE_HALF: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh = {2{wdata[15:0]}};
        rdata    = {16'h0, (addr_lo[1] ? mem_word[31:16] : mem_word[15:0])};
        misalign = ERR_EN && addr_lo[0];
      end
      default: begin
        be       = 4'b1111;
        wdata_sh = wdata;
        rdata    = mem_word;
        misalign = ERR_EN && (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/bus_ram_responder.sv
// Single-port word RAM behind a request/ready bus with WAIT_CYCLES wait states.
// busReq is sampled only in IDLE; busReady pulses one cycle. Build option: MISALIGN_ERR_EN.
module bus_ram_responder
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [1:0]  memSize,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  bus_state_e              state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH+1:0]   lat_addr;
  logic                    lat_we;
  logic [31:0]             lat_wdata;
  logic [1:0]              lat_size;
  logic [31:0]             mem [DEPTH];

  logic                    in_idle;
  logic [ADDR_WIDTH+1:0]   acc_addr;
  logic [1:0]              acc_size;
  logic                    acc_we;
  logic [3:0]              be;
  logic [31:0]             wdata_sh;
  logic [31:0]             rdata;
  logic                    misalign;
  logic                    enter_resp;
  logic                    unused_addr_hi;

  // With zero wait states the response is formed on the accept edge, so the
  // lane logic must see the live bus inputs while idle.
  assign in_idle  = (state == IDLE);
  assign acc_addr = in_idle ? busAddr[ADDR_WIDTH+1:0] : lat_addr;
  assign acc_size = in_idle ? memSize : lat_size;
  assign acc_we   = in_idle ? busWe : lat_we;
  assign unused_addr_hi = ^busAddr[31:ADDR_WIDTH+2];

  assign enter_resp = (in_idle && busReq && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));

  bus_lane_align u_align (
    .addr_lo  (acc_addr[1:0]),
    .size     (acc_size),
    .wdata    (lat_wdata),
    .mem_word (mem[acc_addr[ADDR_WIDTH+1:2]]),
    .be       (be),
    .wdata_sh (wdata_sh),
    .rdata    (rdata),
    .misalign (misalign)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      busReady  <= 1'b0;
      busErr    <= 1'b0;
      busRData  <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      lat_size  <= 2'b00;
    end else begin
      busReady <= 1'b0;
      busErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (busReq) begin
            lat_addr  <= busAddr[ADDR_WIDTH+1:0];
            lat_we    <= busWe;
            lat_wdata <= busWData;
            lat_size  <= memSize;
            cnt       <= CNT_INIT;
            state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        busReady <= 1'b1;
        busErr   <= misalign;
        if (misalign)     busRData <= '0;
        else if (!acc_we) busRData <= rdata;
      end
    end
  end

  // Commit happens on the edge that leaves RESP; reset forces IDLE, so an aborted access never writes.
  always_ff @(posedge clk) begin
    if ((state == RESP) && lat_we && !misalign) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[lat_addr[ADDR_WIDTH+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed and random accesses against a byte-array reference model of the bus RAM.
// A second instance with zero wait states covers back-to-back requests and address aliasing.
module tb_bus_ram_responder;
  import bus_pkg::*;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        busReq, busWe;
  logic [31:0] busAddr, busWData;
  logic [1:0]  memSize;
  logic [31:0] busRData;
  logic        busReady, busErr;
  logic [1:0]  dbg_state;

  logic        req0, we0;
  logic [31:0] addr0, wdata0;
  logic [1:0]  size0;
  logic [31:0] rdata0;
  logic        ready0, err0;
  logic [1:0]  dbg0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_mem [0:1023];
  logic [31:0] m_last = 32'h0;

  always #5 clk = ~clk;

  bus_ram_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busWData(busWData), .memSize(memSize), .busRData(busRData), .busReady(busReady),
    .busErr(busErr), .dbg_state(dbg_state)
  );

  bus_ram_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .busReq(req0), .busWe(we0), .busAddr(addr0),
    .busWData(wdata0), .memSize(size0), .busRData(rdata0), .busReady(ready0),
    .busErr(err0), .dbg_state(dbg0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: 1 KiB byte space (addresses wrap), size decides byte count and alignment.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, output logic [31:0] r, output logic e);
    int  nb, base;
    logic mis;
    nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
`ifdef MISALIGN_ERR_EN
    mis = (a % nb) != 0;
`else
    mis = 1'b0;
`endif
    base = int'(a % 32'd1024) - int'(a % nb);
    e = mis;
    if (mis) m_last = 32'h0;
    else if (w) begin
      for (int k = 0; k < nb; k++) m_mem[base + k] = d[8*k +: 8];
    end else begin
      m_last = 32'h0;
      for (int k = 0; k < nb; k++) m_last[8*k +: 8] = m_mem[base + k];
    end
    r = m_last;
  endtask

  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input string tag);
    logic [31:0] exp_r;
    logic        exp_e;
    int          lat;
    model_access(w, a, d, s, exp_r, exp_e);
    busReq = 1'b1; busWe = w; busAddr = a; busWData = d; memSize = s;
    @(posedge clk); lat = 1;
    @(negedge clk); busReq = 1'b0;
    while (!busReady && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(W + 1));
    check({tag, " err"}, {31'b0, busErr}, {31'b0, exp_e});
    check({tag, " rdata"}, busRData, exp_r);
    @(posedge clk);
    @(negedge clk);
    check({tag, " ready one-shot"}, {31'b0, busReady}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    busReq = 1'b0; busWe = 1'b0; busAddr = '0; busWData = '0; memSize = 2'b00;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; size0 = 2'b00;
    repeat (3) @(negedge clk);
    check("reset ready", {31'b0, busReady}, 32'h0);
    check("reset err", {31'b0, busErr}, 32'h0);
    check("reset rdata", busRData, 32'h0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    do_access(1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, "word write 0x10");
    do_access(1'b0, 32'h10, 32'h0, SIZE_WORD, "word read 0x10");
    check("word read constant", busRData, 32'hDEADBEEF);
    do_access(1'b1, 32'h11, 32'h000000AA, SIZE_BYTE, "byte write 0x11");
    do_access(1'b0, 32'h10, 32'h0, SIZE_WORD, "word read after byte");
    check("byte merge constant", busRData, 32'hDEADAAEF);
    do_access(1'b0, 32'h13, 32'h0, SIZE_BYTE, "byte read 0x13");
    check("byte read constant", busRData, 32'h000000DE);
    do_access(1'b1, 32'h12, 32'h00001234, SIZE_HALF, "half write 0x12");
    do_access(1'b0, 32'h12, 32'h0, SIZE_HALF, "half read 0x12");
    check("half read constant", busRData, 32'h00001234);
    do_access(1'b0, 32'h10, 32'h0, SIZE_WORD, "word read after half");
    do_access(1'b1, 32'h11, 32'h00000055, SIZE_WORD, "misaligned word write");
    do_access(1'b0, 32'h10, 32'h0, SIZE_WORD, "word read after misaligned");
    do_access(1'b0, 32'h13, 32'h0, SIZE_HALF, "odd half read");

    // Abort a write while it waits; nothing may commit or respond afterwards.
    busReq = 1'b1; busWe = 1'b1; busAddr = 32'h10; busWData = 32'h0; memSize = SIZE_WORD;
    @(posedge clk);
    @(negedge clk); busReq = 1'b0;
    check("abort in wait", 32'(dbg_state), 32'(WAIT));
    reset = 1'b0;
    m_last = 32'h0;
    #1;
    check("async reset state", 32'(dbg_state), 32'(IDLE));
    check("async reset rdata", busRData, 32'h0);
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("no ready after abort", {31'b0, busReady}, 32'h0);
    end
    do_access(1'b0, 32'h10, 32'h0, SIZE_WORD, "read after abort");

    // Random traffic confined to words 0..15 with random upper bits to exercise wrap.
    for (int i = 0; i < 16; i++)
      do_access(1'b1, 32'(i * 4), $urandom, SIZE_WORD, "init");
    for (int i = 0; i < 60; i++)
      do_access(1'($urandom_range(0, 1)), $urandom & ~32'h3C0, $urandom,
                2'($urandom_range(0, 3)), "random");

    // Zero wait states: a held request is answered every second cycle.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h410; wdata0 = 32'hCAFEF00D; size0 = SIZE_WORD;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("w0 ready cadence", {31'b0, ready0}, 32'((i % 2) == 0));
    end
    we0 = 1'b0; addr0 = 32'h10;
    @(posedge clk);
    @(negedge clk); req0 = 1'b0;
    check("w0 read ready", {31'b0, ready0}, 32'h1);
    check("w0 alias rdata", rdata0, 32'hCAFEF00D);
    check("w0 err", {31'b0, err0}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("w0 ready drop", {31'b0, ready0}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
